prog_loader: RTL and testbench
==============================

# prog_loader

Program-memory writer for the mini CPU. It takes a framed byte stream (length, program bytes, checksum) over a valid/ready handshake and writes the bytes into a 16 x 8 program RAM. The CPU's instruction-fetch path reads that RAM asynchronously through `rd_addr`/`rd_data`. While a load is incomplete or has failed, the block holds the CPU off through `cpu_hold`, which the top level ORs into the CPU/PC reset.

## Interface
- `ADDR_WIDTH`, 4: program address width; RAM depth is 2^ADDR_WIDTH = 16 words.
- `PROG_WIDTH`, 8: program word width, equal to `PROG_WIDTH` in def.svh.
- `CLK`  in  1  system clock; all state changes on posedge.
- `RST_N`  in  1  reset: one clock, asynchronous assert, active-low.
- `start`  in  1  level-sampled request to begin a load session.
- `s_valid`  in  1  stream byte valid.
- `s_data`  in  PROG_WIDTH  stream byte.
- `s_ready`  out  1  block can accept a byte; a transfer occurs on a posedge with `s_valid && s_ready`.
- `rd_addr`  in  ADDR_WIDTH  CPU fetch address (PC).
- `rd_data`  out  PROG_WIDTH  combinational read of `mem[rd_addr]`.
- `cpu_hold`  out  1  high means the CPU must be held in reset.
- `done`  out  1  last session loaded and checksum matched.
- `err`  out  1  last session aborted on a framing or checksum error.
- `len`  out  ADDR_WIDTH+1  number of words written in the current or last session.

## Operation
- States: IDLE, LEN, DATA, SUM, DONE, ERR. All outputs except `rd_data` decode from registered state and counters.
- Reset (RST_N=0), asynchronous:
  - state=IDLE; all 16 words=8'h00; `len`=0; running sum=0.
  - Outputs: `s_ready`=0, `cpu_hold`=1, `done`=0, `err`=0.
- `start`:
  - Honoured only in IDLE, DONE or ERR; ignored in LEN, DATA and SUM.
  - On the accepting edge: all RAM words cleared to 8'h00, `len`=0, sum=0, state goes to LEN.
- LEN (`s_ready`=1): on a transfer, `s_data` is the word count N.
  - Valid when `s_data[7:5]`==0 and 1 <= N <= 16. Latch N, go to DATA.
  - Otherwise go to ERR.
- DATA (`s_ready`=1): on each transfer:
  - `mem[len[3:0]] <= s_data`, `len <= len+1`, `sum <= sum + s_data` (8-bit, wraps mod 256).
  - After the Nth byte, go to SUM.
- SUM (`s_ready`=1): one transfer, checksum byte C.
  - If (sum + C) mod 256 == 0, go to DONE; otherwise go to ERR.
- DONE: `cpu_hold`=0, `done`=1. RAM is frozen.
- ERR: `cpu_hold`=1, `err`=1. RAM keeps its partially written contents for debug.
- `cpu_hold`=0 only in DONE; 1 in every other state.
- `s_ready`=1 only in LEN, DATA and SUM. Bytes presented in other states are not consumed.
- `rd_data` is always `mem[rd_addr]`, including during a load. Words at addresses >= N read 8'h00.

## Timing
- `start` sampled high at edge k: `s_ready`=1 and `cpu_hold`=1 from k onward. The first byte can transfer at edge k+1.
- Stream throughput: one byte per clock. A full 16-word load takes 18 transfer cycles (length + 16 data + checksum).
- Write-to-read: a word written at edge t appears on `rd_data` after edge t (same-address combinational read).
- Final checksum transfer at edge t: `done`/`err` and `cpu_hold` update at t. The CPU leaves reset on the next slow-clock edge after t with PC=0.
- `s_valid` may drop at any time; the FSM waits in its state with no timeout.
- `start` together with a transfer in DONE or ERR: `start` wins, and the byte is not consumed because `s_ready`=0 there.
- RST_N asserted mid-session: immediate return to the reset values above, RAM cleared.
- `len` saturates at N. It reaches 16 only with a 5-bit count, so there is no wrap into address 0.

## Test plan
- Reset: RST_N=0 with junk on all inputs -> `cpu_hold`=1, `s_ready`=0, `done`=`err`=0, `rd_data`=8'h00 for all 16 addresses.
- Nominal load: start; stream 0x03, 0xB1, 0x01, 0xE0, checksum 0x6E -> `done`=1, `cpu_hold`=0, `len`=3, mem[0..2]=B1,01,E0, mem[3..15]=00.
- Bad checksum: same frame with checksum 0x6F -> `err`=1, `cpu_hold`=1, mem[0..2] still B1,01,E0. A following start then clears RAM, drops `err` and returns to LEN.
- Framing errors: length 0x00, 0x11 or 0x23 -> ERR after one transfer with no RAM write. Length 0x10 with 16 bytes whose sum is 0x00 and checksum 0x00 -> DONE, `len`=16.
- Backpressure and ignore: toggle `s_valid` randomly and pulse `start` during DATA -> bytes land only on handshake edges and the session is not restarted.
- Async reset mid-DATA after 5 bytes -> outputs return immediately to their reset values and all words read 00.

Source files
------------

// File: rtl/prog_loader.sv
// prog_loader: framed-byte-stream writer for the mini CPU program RAM.
// A session is: length byte N (1..DEPTH), N program bytes, checksum byte C
// such that (sum of program bytes + C) mod 256 == 0. The RAM is read
// combinationally by the CPU fetch path. cpu_hold keeps the CPU in reset
// until a session completes with a good checksum.
module prog_loader #(
    parameter int ADDR_WIDTH = 4,
    parameter int PROG_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  start,
    input  logic                  s_valid,
    input  logic [PROG_WIDTH-1:0] s_data,
    output logic                  s_ready,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [PROG_WIDTH-1:0] rd_data,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_WIDTH:0]   len
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [PROG_WIDTH-1:0] DEPTH_W = PROG_WIDTH'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE = (ADDR_WIDTH + 1)'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_DATA,
        ST_SUM,
        ST_DONE,
        ST_ERR
    } state_e;

    state_e                state_q, state_d;
    // len_q counts words written this session; target_q holds the framed N.
    // Both are ADDR_WIDTH+1 bits so a full-depth load counts to DEPTH
    // without wrapping back into address 0.
    logic [ADDR_WIDTH:0]   len_q, len_d;
    logic [ADDR_WIDTH:0]   target_q, target_d;
    logic [PROG_WIDTH-1:0] sum_q, sum_d;
    logic [PROG_WIDTH-1:0] mem_q [DEPTH];

    logic                  xfer;
    logic                  len_ok;
    logic                  last_data;
    logic [PROG_WIDTH-1:0] sum_data;
    logic [PROG_WIDTH-1:0] sum_final;
    logic                  mem_clr;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] wr_addr;

    // Registered-state decode of the stream and status outputs.
    assign s_ready  = (state_q == ST_LEN) || (state_q == ST_DATA) || (state_q == ST_SUM);
    assign cpu_hold = (state_q != ST_DONE);
    assign done     = (state_q == ST_DONE);
    assign err      = (state_q == ST_ERR);
    assign len      = len_q;
    assign rd_data  = mem_q[rd_addr];

    assign xfer      = s_valid && s_ready;
    // A length byte is legal only in 1..DEPTH; anything else is a framing error.
    assign len_ok    = (s_data != '0) && (s_data <= DEPTH_W);
    assign last_data = ((len_q + CNT_ONE) == target_q);
    assign sum_data  = sum_q + s_data;
    assign sum_final = sum_q + s_data;
    assign wr_addr   = len_q[ADDR_WIDTH-1:0];

    // Next-state, counter and RAM-write decode.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one
        // unassigned; a missing default here would infer a latch.
        state_d  = state_q;
        len_d    = len_q;
        target_d = target_q;
        sum_d    = sum_q;
        mem_clr  = 1'b0;
        mem_we   = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                // start is only honoured between sessions; it wipes the RAM
                // so words beyond the new N read back as zero.
                if (start) begin
                    state_d = ST_LEN;
                    len_d   = '0;
                    sum_d   = '0;
                    mem_clr = 1'b1;
                end
            end
            ST_LEN: begin
                if (xfer) begin
                    if (len_ok) begin
                        target_d = s_data[ADDR_WIDTH:0];
                        state_d  = ST_DATA;
                    end else begin
                        state_d = ST_ERR;
                    end
                end
            end
            ST_DATA: begin
                if (xfer) begin
                    mem_we = 1'b1;
                    len_d  = len_q + CNT_ONE;
                    sum_d  = sum_data;
                    if (last_data) begin
                        state_d = ST_SUM;
                    end
                end
            end
            ST_SUM: begin
                if (xfer) begin
                    state_d = (sum_final == '0) ? ST_DONE : ST_ERR;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and session counters.
    always_ff @(posedge CLK or negedge RST_N) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples the pre-edge values computed above.
        if (!RST_N) begin
            state_q  <= ST_IDLE;
            len_q    <= '0;
            target_q <= '0;
            sum_q    <= '0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            target_q <= target_d;
            sum_q    <= sum_d;
        end
    end

    // Program RAM: cleared by reset and by an accepted start, one word
    // written per data transfer, otherwise frozen.
    always_ff @(posedge CLK or negedge RST_N) begin
        // NOTE: the RAM is deliberately reset; the fetch path must read 00
        // after reset, which forces a flop array rather than a RAM macro.
        if (!RST_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            mem_q[wr_addr] <= s_data;
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed corner cases, a table of
// framed sessions, and randomized sessions with backpressure checked against
// a frame-level reference model.
module tb_prog_loader;

    logic       CLK;
    logic       RST_N;
    logic       start;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_ready;
    logic [3:0] rd_addr;
    logic [7:0] rd_data;
    logic       cpu_hold;
    logic       done;
    logic       err;
    logic [4:0] len;

    int checks   = 0;
    int failures = 0;

    // Current frame and the model's prediction for it.
    logic [7:0] frame_q[$];
    logic [7:0] model_mem[16];
    logic       model_done;
    logic       model_err;
    logic [4:0] model_len;

    typedef struct {
        logic [7:0] len_byte;
        logic [7:0] seed;
        logic [7:0] sum_off;
        logic       exp_done;
        logic       exp_err;
        logic [4:0] exp_len;
    } vec_t;

    vec_t vecs[8];

    prog_loader #(.ADDR_WIDTH(4), .PROG_WIDTH(8)) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .start    (start),
        .s_valid  (s_valid),
        .s_data   (s_data),
        .s_ready  (s_ready),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err),
        .len      (len)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Frame-level model: outcome of a whole session from its bytes.
    task automatic predict();
        int n;
        int sum;
        n = frame_q[0];
        for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;
        model_done = 1'b0;
        model_err  = 1'b1;
        model_len  = 5'd0;
        if (n >= 1 && n <= 16) begin
            sum = 0;
            for (int i = 0; i < n; i++) begin
                model_mem[i] = frame_q[1 + i];
                sum += frame_q[1 + i];
            end
            model_len = 5'(n);
            if (((sum + frame_q[n + 1]) % 256) == 0) begin
                model_done = 1'b1;
                model_err  = 1'b0;
            end
        end
    endtask

    // Length byte, deterministic data, checksum offset from the correct value.
    task automatic build_frame(input logic [7:0] len_byte, input logic [7:0] seed,
                               input logic [7:0] sum_off);
        int sum;
        logic [7:0] b;
        frame_q.delete();
        frame_q.push_back(len_byte);
        if (len_byte >= 1 && len_byte <= 16) begin
            sum = 0;
            for (int i = 0; i < len_byte; i++) begin
                b = 8'(i * 37 + seed);
                frame_q.push_back(b);
                sum += b;
            end
            frame_q.push_back(8'(256 - (sum % 256) + sum_off));
        end
    endtask

    task automatic do_start();
        @(negedge CLK);
        start   = 1'b1;
        s_valid = 1'b0;
        @(negedge CLK);
        start   = 1'b0;
    endtask

    // Streams frame_q; call at a negedge with the DUT in LEN.
    task automatic send_frame(input int valid_pct, input bit poke_start, input bit check_len);
        int  idx    = 0;
        int  cycles = 0;
        int  n_eff;
        int  exp_l;
        bit  xfer;
        n_eff = (frame_q[0] >= 1 && frame_q[0] <= 16) ? int'(frame_q[0]) : 0;
        while (idx < frame_q.size()) begin
            s_valid = ($urandom_range(99) < valid_pct);
            s_data  = s_valid ? frame_q[idx] : 8'($urandom);
            start   = poke_start && (idx >= 1) && ($urandom_range(3) == 0);
            xfer    = s_valid && s_ready;
            @(posedge CLK);
            if (xfer) idx++;
            @(negedge CLK);
            cycles++;
            if (check_len) begin
                exp_l = (idx <= 1) ? 0 : ((idx - 1 > n_eff) ? n_eff : idx - 1);
                check("len_track", len, exp_l);
            end
            if (cycles > 400) begin
                checks++;
                failures++;
                $display("FAIL stream_timeout: got %0d of %0d bytes accepted", idx, frame_q.size());
                break;
            end
        end
        s_valid = 1'b0;
        start   = 1'b0;
    endtask

    task automatic check_outcome(input string tag);
        check({tag, ".done"}, done, model_done);
        check({tag, ".err"}, err, model_err);
        check({tag, ".cpu_hold"}, cpu_hold, !model_done);
        check({tag, ".s_ready"}, s_ready, 1'b0);
        check({tag, ".len"}, len, model_len);
        for (int i = 0; i < 16; i++) begin
            rd_addr = 4'(i);
            #1;
            check($sformatf("%s.mem[%0d]", tag, i), rd_data, model_mem[i]);
        end
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < 16; i++) begin
            rd_addr = 4'(i);
            #1;
            check($sformatf("%s.mem[%0d]", tag, i), rd_data, 8'h00);
        end
    endtask

    initial begin
        vecs[0] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 5'd0};
        vecs[1] = '{8'h11, 8'h00, 8'h00, 1'b0, 1'b1, 5'd0};
        vecs[2] = '{8'h23, 8'h00, 8'h00, 1'b0, 1'b1, 5'd0};
        vecs[3] = '{8'h01, 8'h5A, 8'h00, 1'b1, 1'b0, 5'd1};
        vecs[4] = '{8'h10, 8'h13, 8'h00, 1'b1, 1'b0, 5'd16};
        vecs[5] = '{8'h05, 8'h77, 8'h01, 1'b0, 1'b1, 5'd5};
        vecs[6] = '{8'h08, 8'hC4, 8'h80, 1'b0, 1'b1, 5'd8};
        vecs[7] = '{8'h0F, 8'h29, 8'h00, 1'b1, 1'b0, 5'd15};

        // Reset with junk on every input.
        RST_N   = 1'b0;
        start   = 1'b1;
        s_valid = 1'b1;
        s_data  = 8'hA5;
        rd_addr = 4'h7;
        repeat (3) @(negedge CLK);
        check("rst.cpu_hold", cpu_hold, 1'b1);
        check("rst.s_ready", s_ready, 1'b0);
        check("rst.done", done, 1'b0);
        check("rst.err", err, 1'b0);
        check("rst.len", len, 5'd0);
        check_all_zero("rst");
        start   = 1'b0;
        s_valid = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        check("idle.s_ready", s_ready, 1'b0);
        check("idle.cpu_hold", cpu_hold, 1'b1);

        // Nominal load.
        do_start();
        check("start.s_ready", s_ready, 1'b1);
        check("start.cpu_hold", cpu_hold, 1'b1);
        frame_q = '{8'h03, 8'hB1, 8'h01, 8'hE0, 8'h6E};
        predict();
        send_frame(100, 1'b0, 1'b1);
        check("nominal.done_const", done, 1'b1);
        check_outcome("nominal");

        // start together with a byte in DONE: start wins, byte not consumed.
        @(negedge CLK);
        start   = 1'b1;
        s_valid = 1'b1;
        s_data  = 8'h02;
        @(negedge CLK);
        start   = 1'b0;
        s_valid = 1'b0;
        rd_addr = 4'h0;
        #1;
        check("restart.s_ready", s_ready, 1'b1);
        check("restart.done", done, 1'b0);
        check("restart.len", len, 5'd0);
        check("restart.mem0", rd_data, 8'h00);

        // Bad checksum keeps partial RAM contents.
        @(negedge CLK);
        frame_q = '{8'h03, 8'hB1, 8'h01, 8'hE0, 8'h6F};
        predict();
        send_frame(100, 1'b0, 1'b1);
        check("badsum.err_const", err, 1'b1);
        check_outcome("badsum");

        // start after an error clears RAM and status, returns to LEN.
        do_start();
        check("err_restart.err", err, 1'b0);
        check("err_restart.s_ready", s_ready, 1'b1);
        check("err_restart.cpu_hold", cpu_hold, 1'b1);
        check_all_zero("err_restart");
        @(negedge CLK);
        frame_q = '{8'h23};
        predict();
        send_frame(100, 1'b0, 1'b1);
        check_outcome("len23");

        // Full-depth load of 16 x 0x10 (sum wraps to 0) with checksum 0.
        do_start();
        frame_q = '{8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10,
                    8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h00};
        predict();
        send_frame(100, 1'b0, 1'b1);
        check("full.len_const", len, 5'd16);
        check_outcome("full");

        // Table of sessions.
        for (int v = 0; v < 8; v++) begin
            do_start();
            build_frame(vecs[v].len_byte, vecs[v].seed, vecs[v].sum_off);
            predict();
            send_frame(100, 1'b0, 1'b1);
            check($sformatf("vec%0d.done", v), done, vecs[v].exp_done);
            check($sformatf("vec%0d.err", v), err, vecs[v].exp_err);
            check($sformatf("vec%0d.len", v), len, vecs[v].exp_len);
            check_outcome($sformatf("vec%0d", v));
        end

        // Randomized sessions with backpressure and ignored start pulses.
        for (int r = 0; r < 24; r++) begin
            int n;
            int sum;
            do_start();
            frame_q.delete();
            if ($urandom_range(7) == 0) begin
                frame_q.push_back($urandom_range(1) ? 8'h00 : 8'($urandom_range(255, 17)));
            end else begin
                n   = $urandom_range(16, 1);
                sum = 0;
                frame_q.push_back(8'(n));
                for (int i = 0; i < n; i++) begin
                    frame_q.push_back(8'($urandom));
                    sum += frame_q[1 + i];
                end
                if ($urandom_range(3) != 0) frame_q.push_back(8'(256 - (sum % 256)));
                else frame_q.push_back(8'($urandom));
            end
            predict();
            send_frame($urandom_range(100, 30), 1'b1, 1'b1);
            check_outcome($sformatf("rand%0d", r));
        end

        // Asynchronous reset in the middle of DATA after 5 bytes.
        do_start();
        build_frame(8'h08, 8'h41, 8'h00);
        for (int i = 0; i < 6; i++) begin
            s_valid = 1'b1;
            s_data  = frame_q[i];
            @(negedge CLK);
        end
        s_valid = 1'b0;
        rd_addr = 4'h4;
        #1;
        check("midrst.len_before", len, 5'd5);
        check("midrst.mem4_before", rd_data, frame_q[5]);
        #1;
        RST_N = 1'b0;
        #1;
        check("midrst.s_ready", s_ready, 1'b0);
        check("midrst.cpu_hold", cpu_hold, 1'b1);
        check("midrst.done", done, 1'b0);
        check("midrst.err", err, 1'b0);
        check("midrst.len", len, 5'd0);
        check_all_zero("midrst");
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
